// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port: grants one port at a time,
// holds the strobe for MEM_LATENCY cycles, then returns read data with an ACK pulse.
module mem_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 26,
  parameter int MEM_LATENCY = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  RNW0,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  output logic                  ACK0,
  output logic [DATA_WIDTH-1:0] RDATA0,
  input  logic                  REQ1,
  input  logic                  RNW1,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  ACK1,
  output logic [DATA_WIDTH-1:0] RDATA1,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  output logic                  BUSY,
  output logic                  GRANT
);

  // An illegal latency setting degrades to a single-cycle access.
  localparam int LAT = (MEM_LATENCY < 1 || MEM_LATENCY > 15) ? 1 : MEM_LATENCY;
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  rnw_q, rnw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  busy_q, busy_d;
  logic                  win;
  logic                  cmd_rnw;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    rnw_d        = rnw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    busy_d       = busy_q;
    win          = 1'b0;
    cmd_rnw      = 1'b0;

    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          // On a tie, round-robin favours whichever port did not go last.
          if (REQ0 && REQ1) win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
          else              win = REQ1;
          cmd_rnw     = win ? RNW1 : RNW0;
          grant_d     = win;
          rnw_d       = cmd_rnw;
          addr_d      = win ? ADDR1 : ADDR0;
          wdata_d     = win ? WDATA1 : WDATA0;
          cnt_d       = CNT_LOAD;
          mem_read_d  = cmd_rnw;
          mem_write_d = ~cmd_rnw;
          busy_d      = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          ack0_d      = ~grant_q;
          ack1_d      = grant_q;
          if (rnw_q && !grant_q) rdata0_d = MEM_RDATA;
          if (rnw_q && grant_q)  rdata1_d = MEM_RDATA;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      rnw_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      rnw_q        <= rnw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign ACK0      = ack0_q;
  assign ACK1      = ack1_q;
  assign RDATA0    = rdata0_q;
  assign RDATA1    = rdata1_q;
  assign MEM_READ  = mem_read_q;
  assign MEM_WRITE = mem_write_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign BUSY      = busy_q;
  assign GRANT     = grant_q;

endmodule
